// File: rtl/ifu_fetch.sv
// Instruction fetch stage: owns the architectural PC and issues word fetches
// to instruction memory. Returned words are buffered and handed to decode as
// {instr, instr_pc}. Redirects and halts flush the buffer and discard stale
// responses.
// Optional build macro: IFU_BYPASS_EN. It lets a response go straight to
// decode in its arrival cycle when the buffer is empty.

module ifu_fetch #(
    parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
    parameter int          FIFO_DEPTH = 2,
    parameter int          INSTR_SIZE = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  imem_req_valid,
    input  logic                  imem_req_ready,
    output logic [63:0]           imem_req_addr,
    input  logic                  imem_rsp_valid,
    input  logic [INSTR_SIZE-1:0] imem_rsp_data,
    input  logic                  redirect_valid,
    input  logic [63:0]           redirect_pc,
    input  logic                  halt,
    output logic                  instr_valid,
    output logic [INSTR_SIZE-1:0] instr,
    output logic [63:0]           instr_pc,
    input  logic                  instr_ready,
    output logic                  halted
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [CW-1:0] ZERO_C  = CW'(0);
    localparam logic [AW-1:0] PONE_C  = AW'(1);
    localparam logic [AW-1:0] PZERO_C = AW'(0);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    state_t                  state_r;
    state_t                  state_s;
    logic [63:0]             pc_r;
    logic [CW-1:0]           inflight_r;
    logic [CW-1:0]           drop_r;
    logic [CW-1:0]           inflight_next_s;

    // instruction buffer
    logic [INSTR_SIZE-1:0]   ib_data_r [FIFO_DEPTH];
    logic [63:0]             ib_pc_r   [FIFO_DEPTH];
    logic [AW-1:0]           ib_rd_r;
    logic [AW-1:0]           ib_wr_r;
    logic [CW-1:0]           ib_cnt_r;

    // request-PC queue, written at acceptance, read by kept responses
    logic [63:0]             pq_pc_r [FIFO_DEPTH];
    logic [AW-1:0]           pq_rd_r;
    logic [AW-1:0]           pq_wr_r;

    logic                    run_s;
    logic                    halt_now_s;
    logic                    redir_now_s;
    logic                    flush_s;
    logic                    credit_s;
    logic                    req_valid_s;
    logic                    accept_s;
    logic                    rsp_dec_s;
    logic                    keep_rsp_s;
    logic                    drop_rsp_s;
    logic                    ib_empty_s;
    logic                    fifo_vis_s;
    logic                    bypass_s;
    logic                    push_s;
    logic                    pop_s;
    logic [63:0]             pq_head_s;
    logic [CW:0]             occ_s;

    // Control decode: request credit, response routing, flush conditions
    always_comb begin
        run_s       = (state_r == ST_RUN);
        halt_now_s  = run_s && halt;
        redir_now_s = run_s && !halt && redirect_valid;
        flush_s     = halt_now_s || redir_now_s;
        occ_s       = {1'b0, inflight_r} + {1'b0, ib_cnt_r};
        credit_s    = (occ_s < {1'b0, DEPTH_C});
        req_valid_s = run_s && !halt && !redirect_valid && credit_s;
        accept_s    = req_valid_s && imem_req_ready;
        rsp_dec_s   = imem_rsp_valid && (inflight_r != ZERO_C);
        // a response in a redirect/halt cycle is discarded along with the rest
        keep_rsp_s  = imem_rsp_valid && run_s && !halt && !redirect_valid && (drop_r == ZERO_C);
        drop_rsp_s  = imem_rsp_valid && run_s && !halt && !redirect_valid && (drop_r != ZERO_C);
        ib_empty_s  = (ib_cnt_r == ZERO_C);
        fifo_vis_s  = !ib_empty_s && (state_r != ST_HALT);
        pq_head_s   = pq_pc_r[pq_rd_r];
`ifdef IFU_BYPASS_EN
        bypass_s    = keep_rsp_s && ib_empty_s;
`else
        bypass_s    = 1'b0;
`endif
        push_s      = keep_rsp_s && !(bypass_s && instr_ready);
        pop_s       = fifo_vis_s && instr_ready;
    end

    // Outstanding-fetch count after this cycle's acceptance and response
    always_comb begin
        inflight_next_s = inflight_r;
        if (accept_s && !rsp_dec_s) begin
            inflight_next_s = inflight_r + ONE_C;
        end else if (!accept_s && rsp_dec_s) begin
            inflight_next_s = inflight_r - ONE_C;
        end else begin
            inflight_next_s = inflight_r;
        end
    end

    // FSM next state: BOOT lasts one cycle, HALT is sticky until reset
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_BOOT: state_s = ST_RUN;
            ST_RUN: begin
                if (halt) begin
                    state_s = ST_HALT;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_HALT: state_s = ST_HALT;
            default: state_s = ST_BOOT;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_BOOT;
        end else begin
            state_r <= state_s;
        end
    end

    // Architectural PC: redirect target (word aligned) or sequential advance
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r <= RESET_PC;
        end else if (redir_now_s) begin
            pc_r <= redirect_pc & 64'hFFFF_FFFF_FFFF_FFFC;
        end else if (accept_s) begin
            pc_r <= pc_r + 64'd4;
        end else begin
            pc_r <= pc_r;
        end
    end

    // Outstanding fetches and number of stale responses still to discard
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inflight_r <= ZERO_C;
            drop_r     <= ZERO_C;
        end else begin
            inflight_r <= inflight_next_s;
            if (halt_now_s) begin
                drop_r <= ZERO_C;
            end else if (redir_now_s) begin
                drop_r <= inflight_next_s;
            end else if (drop_rsp_s) begin
                drop_r <= drop_r - ONE_C;
            end else begin
                drop_r <= drop_r;
            end
        end
    end

    // Instruction buffer: push kept responses, pop on decode handshake
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ib_rd_r  <= PZERO_C;
            ib_wr_r  <= PZERO_C;
            ib_cnt_r <= ZERO_C;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ib_data_r[i] <= {INSTR_SIZE{1'b0}};
                ib_pc_r[i]   <= 64'd0;
            end
        end else if (flush_s) begin
            ib_rd_r  <= PZERO_C;
            ib_wr_r  <= PZERO_C;
            ib_cnt_r <= ZERO_C;
        end else begin
            if (push_s) begin
                ib_data_r[ib_wr_r] <= imem_rsp_data;
                ib_pc_r[ib_wr_r]   <= pq_head_s;
                ib_wr_r            <= ib_wr_r + PONE_C;
            end
            if (pop_s) begin
                ib_rd_r <= ib_rd_r + PONE_C;
            end
            if (push_s && !pop_s) begin
                ib_cnt_r <= ib_cnt_r + ONE_C;
            end else if (!push_s && pop_s) begin
                ib_cnt_r <= ib_cnt_r - ONE_C;
            end else begin
                ib_cnt_r <= ib_cnt_r;
            end
        end
    end

    // Request-PC queue: dropped responses never consume an entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pq_rd_r <= PZERO_C;
            pq_wr_r <= PZERO_C;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                pq_pc_r[i] <= 64'd0;
            end
        end else if (flush_s) begin
            pq_rd_r <= PZERO_C;
            pq_wr_r <= PZERO_C;
        end else begin
            if (accept_s) begin
                pq_pc_r[pq_wr_r] <= pc_r;
                pq_wr_r          <= pq_wr_r + PONE_C;
            end
            if (keep_rsp_s) begin
                pq_rd_r <= pq_rd_r + PONE_C;
            end
        end
    end

    // Decode-side outputs: buffer head, or the arriving response on bypass
    always_comb begin
        instr_valid = 1'b0;
        instr       = {INSTR_SIZE{1'b0}};
        instr_pc    = 64'd0;
        if (fifo_vis_s) begin
            instr_valid = 1'b1;
            instr       = ib_data_r[ib_rd_r];
            instr_pc    = ib_pc_r[ib_rd_r];
        end else if (bypass_s) begin
            instr_valid = 1'b1;
            instr       = imem_rsp_data;
            instr_pc    = pq_head_s;
        end else begin
            instr_valid = 1'b0;
        end
    end

    assign imem_req_valid = req_valid_s;
    assign imem_req_addr  = pc_r;
    assign halted         = (state_r == ST_HALT);

    ifu_fetch_chk #(.CW(CW)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .count (ib_cnt_r),
        .depth (DEPTH_C)
    );

endmodule

// Invariant checker for the fetch buffer.
module ifu_fetch_chk #(
    parameter int CW = 2
) (
    input logic          clk,
    input logic          rst,
    input logic          push,
    input logic [CW-1:0] count,
    input logic [CW-1:0] depth
);

    // the credit rule must keep the buffer from ever being written while full
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(push && (count == depth)));

endmodule

// File: tb/tb_ifu_fetch.sv
// Scoreboard bench for ifu_fetch: directed scenarios push expected request
// addresses and delivered {pc, instr} pairs; a monitor pops and compares.

module tb_ifu_fetch;

    logic        clk;
    logic        rst;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [63:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [63:0] redirect_pc;
    logic        halt;
    logic        instr_valid;
    logic [31:0] instr;
    logic [63:0] instr_pc;
    logic        instr_ready;
    logic        halted;

    int n_pass  = 0;
    int n_total = 0;
    int acc_count = 0;
    int acc_base  = 0;
    int cyc = 0;

    logic [63:0] exp_addr[$];
    logic [63:0] exp_pc[$];
    logic [31:0] exp_data[$];
    logic [63:0] pend_addr[$];
    int          pend_cyc[$];

    logic        fire = 1'b0;
    logic [63:0] fire_addr = 64'd0;
    logic        mem_hold = 1'b0;
    int          mem_lat = 1;

    ifu_fetch dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready),
        .halted         (halted)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdata(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hA5A5_5A5A;
    endfunction

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic expect_fetch(input logic [63:0] a, input bit deliver);
        exp_addr.push_back(a);
        if (deliver) begin
            exp_pc.push_back(a);
            exp_data.push_back(mdata(a));
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // wait (bounded) for both scoreboards to empty
    task automatic drain(input int budget);
        int n = 0;
        while ((exp_addr.size() != 0 || exp_pc.size() != 0) && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drain_addr_left", 64'(exp_addr.size()), 64'd0);
        check("drain_instr_left", 64'(exp_pc.size()), 64'd0);
    endtask

    // reset, check reset outputs and the idle BOOT cycle; returns in first RUN cycle
    task automatic do_reset(input bit boot_redir);
        rst = 1'b0;
        halt = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        @(negedge clk);
        check("rst_req_valid", 64'(imem_req_valid), 64'd0);
        check("rst_instr_valid", 64'(instr_valid), 64'd0);
        check("rst_halted", 64'(halted), 64'd0);
        check("rst_instr", 64'(instr), 64'd0);
        check("rst_instr_pc", instr_pc, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        if (boot_redir) begin
            redirect_valid = 1'b1;
            redirect_pc = 64'h0000_0000_1234_0000;
        end
        @(negedge clk);
        check("boot_no_req", 64'(imem_req_valid), 64'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        acc_base = acc_count;
    endtask

    // monitor: request-channel and decode-channel scoreboards
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            fire = rst && imem_req_valid && imem_req_ready;
            fire_addr = imem_req_addr;
            if (rst && imem_req_valid && imem_req_ready) begin
                acc_count++;
                if (exp_addr.size() != 0) begin
                    e = exp_addr.pop_front();
                    check("req_addr", imem_req_addr, e);
                end
            end
            if (rst && instr_valid && instr_ready && exp_pc.size() != 0) begin
                check("instr_pc", instr_pc, exp_pc.pop_front());
                check("instr_data", 64'(instr), 64'(exp_data.pop_front()));
            end
        end
    end

    // memory model: in-order responses mem_lat cycles after acceptance
    initial begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data = 32'd0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            if (!rst) begin
                pend_addr.delete();
                pend_cyc.delete();
                imem_rsp_valid = 1'b0;
                imem_rsp_data = 32'd0;
            end else begin
                if (fire) begin
                    pend_addr.push_back(fire_addr);
                    pend_cyc.push_back(cyc);
                end
                if (!mem_hold && pend_addr.size() != 0 && (pend_cyc[0] + mem_lat - 1) <= cyc) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data = mdata(pend_addr.pop_front());
                    void'(pend_cyc.pop_front());
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data = 32'd0;
                end
            end
        end
    end

    // watchdog
    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // directed scenarios
    initial begin
        rst = 1'b0;
        imem_req_ready = 1'b1;
        instr_ready = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc = 64'd0;
        halt = 1'b0;

        // 1: streaming fetch from RESET_PC
        mem_lat = 1;
        mem_hold = 1'b0;
        do_reset(1'b0);
        expect_fetch(64'h8000_0000, 1'b1);
        expect_fetch(64'h8000_0004, 1'b1);
        expect_fetch(64'h8000_0008, 1'b1);
        expect_fetch(64'h8000_000C, 1'b1);
        drain(60);

        // 2: decode stalled, credit limit then resume
        instr_ready = 1'b0;
        do_reset(1'b0);
        expect_fetch(64'h8000_0000, 1'b1);
        expect_fetch(64'h8000_0004, 1'b1);
        expect_fetch(64'h8000_0008, 1'b1);
        cycles(8);
        @(negedge clk);
        check("stall_accepts", 64'(acc_count - acc_base), 64'd2);
        check("stall_req_valid", 64'(imem_req_valid), 64'd0);
        check("stall_instr_valid", 64'(instr_valid), 64'd1);
        check("stall_head_pc", instr_pc, 64'h8000_0000);
        @(posedge clk);
        #1;
        instr_ready = 1'b1;
        drain(60);

        // 3: redirect with two fetches in flight
        mem_hold = 1'b1;
        do_reset(1'b0);
        expect_fetch(64'h8000_0000, 1'b0);
        expect_fetch(64'h8000_0004, 1'b0);
        expect_fetch(64'h8000_1000, 1'b1);
        expect_fetch(64'h8000_1004, 1'b1);
        cycles(6);
        @(negedge clk);
        check("inflight_accepts", 64'(acc_count - acc_base), 64'd2);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_8000_1002;
        @(negedge clk);
        check("redir_req_forced0", 64'(imem_req_valid), 64'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        mem_hold = 1'b0;
        drain(60);

        // 4: redirect while a request is pending and a response arrives
        do_reset(1'b0);
        expect_fetch(64'h8000_0000, 1'b0);
        expect_fetch(64'h8000_2000, 1'b1);
        expect_fetch(64'h8000_2004, 1'b1);
        @(posedge clk);
        #1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_8000_2000;
        @(negedge clk);
        check("redir2_req_forced0", 64'(imem_req_valid), 64'd0);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        drain(60);

        // 5: halt together with redirect; late responses ignored
        mem_hold = 1'b1;
        do_reset(1'b0);
        expect_fetch(64'h8000_0000, 1'b0);
        expect_fetch(64'h8000_0004, 1'b0);
        cycles(6);
        halt = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 64'h0000_0000_9000_0000;
        @(negedge clk);
        check("halt_cycle_req", 64'(imem_req_valid), 64'd0);
        check("halt_cycle_halted", 64'(halted), 64'd0);
        @(posedge clk);
        #1;
        halt = 1'b0;
        mem_hold = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("halted_flag", 64'(halted), 64'd1);
            check("halted_instr_valid", 64'(instr_valid), 64'd0);
            check("halted_req_valid", 64'(imem_req_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        redirect_valid = 1'b0;
        check("halted_accepts", 64'(acc_count - acc_base), 64'd2);
        drain(5);

        // 6: PC wraps from the top of the address space
        do_reset(1'b0);
        expect_fetch(64'hFFFF_FFFF_FFFF_FFFC, 1'b1);
        expect_fetch(64'h0000_0000_0000_0000, 1'b1);
        expect_fetch(64'h0000_0000_0000_0004, 1'b1);
        redirect_valid = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
        drain(60);

        // 7: redirect during BOOT is ignored; slower memory
        mem_lat = 3;
        do_reset(1'b1);
        expect_fetch(64'h8000_0000, 1'b1);
        expect_fetch(64'h8000_0004, 1'b1);
        expect_fetch(64'h8000_0008, 1'b1);
        drain(80);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
